axi_clint_xbar: RTL

- 1-master/2-slave AXI-lite style demux between the core's LSU data port and the data-side slaves.
- Slave 0 is main memory (default); slave 1 is the CLINT (mtime/mtimecmp block).
- Read and write paths are independent FSMs. Each routes one outstanding transaction, with the slave selection latched at address acceptance.

---
 rtl/axi_clint_xbar.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_clint_xbar.sv
// One-master / two-slave AXI-lite demux: slave 0 is main memory, slave 1 is the CLINT.
// The read and write paths are independent FSMs, each carrying one transaction with the route latched at address time.
module axi_clint_xbar #(
  parameter int                          AXI_DATA_WIDTH = 64,
  parameter int                          AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]   CLINT_BASE     = 32'h0200_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]   CLINT_MASK     = 32'hFFFF_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_aw_valid,
  output logic                          m_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_aw_addr,
  input  logic                          m_w_valid,
  output logic                          m_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_w_strb,
  output logic                          m_b_valid,
  input  logic                          m_b_ready,
  input  logic                          m_ar_valid,
  output logic                          m_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_ar_addr,
  output logic                          m_r_valid,
  input  logic                          m_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]     m_r_data,
  output logic [1:0]                    s_aw_valid,
  input  logic [1:0]                    s_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr,
  output logic [1:0]                    s_w_valid,
  input  logic [1:0]                    s_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]     s_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb,
  input  logic [1:0]                    s_b_valid,
  output logic [1:0]                    s_b_ready,
  output logic [1:0]                    s_ar_valid,
  input  logic [1:0]                    s_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr,
  input  logic [1:0]                    s_r_valid,
  output logic [1:0]                    s_r_ready,
  input  logic [2*AXI_DATA_WIDTH-1:0]   s_r_data
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_e;

  rstate_e                     rstate_q, rstate_d;
  wstate_e                     wstate_q, wstate_d;
  logic [AXI_ADDR_WIDTH-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic                        rsel_q, rsel_d, wsel_q, wsel_d;

  function automatic logic is_clint(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a & CLINT_MASK) == CLINT_BASE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
      raddr_q  <= '0;
      waddr_q  <= '0;
      rsel_q   <= 1'b0;
      wsel_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      rsel_q   <= rsel_d;
      wsel_q   <= wsel_d;
    end
  end

  assign s_ar_addr = raddr_q;
  assign s_aw_addr = waddr_q;
  assign s_w_data  = m_w_data;
  assign s_w_strb  = m_w_strb;

  // Read path
  always_comb begin
    rstate_d   = rstate_q;
    raddr_d    = raddr_q;
    rsel_d     = rsel_q;
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b0;
    m_r_data   = '0;
    s_ar_valid = 2'b00;
    s_r_ready  = 2'b00;
    unique case (rstate_q)
      R_IDLE: begin
        // IDLE is also the reset state; keep the master held off while reset is low.
        m_ar_ready = rst;
        if (m_ar_valid) begin
          raddr_d  = m_ar_addr;
          rsel_d   = is_clint(m_ar_addr);
          rstate_d = R_AR;
        end
      end
      R_AR: begin
        s_ar_valid[rsel_q] = 1'b1;
        if (s_ar_ready[rsel_q]) rstate_d = R_DATA;
      end
      R_DATA: begin
        m_r_valid         = s_r_valid[rsel_q];
        m_r_data          = rsel_q ? s_r_data[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                                   : s_r_data[AXI_DATA_WIDTH-1:0];
        s_r_ready[rsel_q] = m_r_ready;
        if (s_r_valid[rsel_q] && m_r_ready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write path; W beats are held off until the address has been issued.
  always_comb begin
    wstate_d   = wstate_q;
    waddr_d    = waddr_q;
    wsel_d     = wsel_q;
    m_aw_ready = 1'b0;
    m_w_ready  = 1'b0;
    m_b_valid  = 1'b0;
    s_aw_valid = 2'b00;
    s_w_valid  = 2'b00;
    s_b_ready  = 2'b00;
    unique case (wstate_q)
      W_IDLE: begin
        m_aw_ready = rst;
        if (m_aw_valid) begin
          waddr_d  = m_aw_addr;
          wsel_d   = is_clint(m_aw_addr);
          wstate_d = W_AW;
        end
      end
      W_AW: begin
        s_aw_valid[wsel_q] = 1'b1;
        if (s_aw_ready[wsel_q]) wstate_d = W_DATA;
      end
      W_DATA: begin
        s_w_valid[wsel_q] = m_w_valid;
        m_w_ready         = s_w_ready[wsel_q];
        if (m_w_valid && s_w_ready[wsel_q]) wstate_d = W_RESP;
      end
      W_RESP: begin
        m_b_valid         = s_b_valid[wsel_q];
        s_b_ready[wsel_q] = m_b_ready;
        if (s_b_valid[wsel_q] && m_b_ready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

endmodule
